iface_arbiter: RTL and testbench
================================

Name: iface_arbiter

Overview:
- Shares the single 128-bit memory interface port between N_REQ masters, e.g. the GEMM unit's operand/result mover and a future DMA engine.
- Uses round-robin arbitration with burst locking and tags reads, so each 1-cycle-latency read response returns to the requester that issued it.
- Sits between the masters and the memory interface port, i.e. the interface_* signals of the memory block.

Parameters:
N_REQ, 2, number of requesters (2..4)
A_WID, 32, address width
D_WID, 128, data width
C_WID, 5, interface_control width
MAX_BURST, 16, maximum beats per grant before forced release (>=1)

Ports:
clk  input  1  clock
rst  input  1  synchronous active-high reset
req_valid  input  N_REQ  requester i has a beat
req_ready  output  N_REQ  beat of requester i accepted this cycle
req_last  input  N_REQ  beat is last of burst
req_rdwr  input  N_REQ  1=write, 0=read
req_addr  input  N_REQ*A_WID  packed addresses, requester i at [i*A_WID +: A_WID]
req_wr_data  input  N_REQ*D_WID  packed write data
req_control  input  N_REQ*C_WID  packed interface_control values
rsp_valid  output  N_REQ  read data valid for requester i
rsp_rd_data  output  D_WID  read data, shared, qualified by rsp_valid
interface_en  output  1  memory access enable
interface_rdwr  output  1  1=write, 0=read
interface_addr  output  A_WID  memory address
interface_wr_data  output  D_WID  memory write data
interface_control  output  C_WID  memory control
interface_rd_data  input  D_WID  memory read data, valid 1 cycle after a read beat

Behaviour:
Reset state:
- State is IDLE, owner=0, rr_ptr=0, beat_cnt=0, rsp pipeline empty.
- All outputs are 0 during and after reset until the first grant.
Arbitration in IDLE:
- If any req_valid is high, the winner is the first requester with req_valid, searching circularly from rr_ptr.
- Register owner=winner and go to GRANT; no beat is accepted in the IDLE cycle.
- This gives 1-cycle arbitration latency from IDLE.
- If no req_valid is high, stay in IDLE.
Beat acceptance in GRANT:
- req_ready[i] = (state==GRANT) && (owner==i) && req_valid[i].
- interface_en = req_ready[owner].
- interface_rdwr, interface_addr, interface_wr_data and interface_control are combinationally muxed from the owner's slices.
- When interface_en=0 these outputs are 0.
- Each accepted beat increments beat_cnt.
Holding the grant:
- If the owner drops req_valid mid-burst, it keeps the grant and no beat is issued.
- Other requesters wait; there is no timeout.
Release:
- Release occurs on an accepted beat with req_last[owner]=1, or on the accepted beat that makes beat_cnt==MAX_BURST (forced release).
- On release: rr_ptr=(owner+1) mod N_REQ and beat_cnt=0.
- In the release cycle, the next winner is chosen from the current req_valid, excluding the releasing owner's own beat, searching circularly from owner+1.
- The releasing owner may win again only if no other requester is valid.
- If there is a winner, stay in GRANT with the new owner and no bubble. Otherwise go to IDLE.
Read return:
- An accepted read beat registers rsp_pend=1 and rsp_id=owner.
- On the next cycle: rsp_valid[rsp_id]=rsp_pend and rsp_rd_data=interface_rd_data, passed through combinationally.
- Routing is by rsp_id, not by the current owner, so it is correct across a handoff.
- Writes produce no response.
- When rsp_valid is all zero, rsp_rd_data is 0.
Reset mid-operation:
- Aborts the burst and drops any pending response; rsp_valid is 0 the next cycle.
FSM and sizing:
- Two states (IDLE, GRANT).
- beat_cnt is $clog2(MAX_BURST+1) bits.
- owner and rr_ptr are $clog2(N_REQ) bits (minimum 1).

Test Plan:
- Reset, then req 0 issues a 3-beat read burst (addr 0x100, 0x110, 0x120, last on beat 3) -> requirements:
  - cycle 1 is idle arbitration;
  - interface_en is high for 3 cycles with those addresses;
  - rsp_valid[0] pulses 3 times, each 1 cycle after its beat, carrying the memory data;
  - state returns to IDLE.
- Req 0 and req 1 both valid in the same cycle after reset, each a 2-beat write -> req 0 is granted first (rr_ptr=0); req 1 takes over with no bubble right after req 0's last beat; rr_ptr ends at 0.
- Req 1 holds req_valid for 20 beats with req_last never asserted, MAX_BURST=16, req 0 waiting -> forced release after beat 16; req 0 is granted on the next cycle; req 1's remaining 4 beats follow after req 0's burst.
- Req 0's final beat is a read and req 1's first beat (next cycle) is a write -> rsp_valid[0]=1 with the read data during req 1's write cycle; rsp_valid[1] stays 0.
- Owner drops req_valid for 3 cycles mid-burst while req 1 is valid -> no interface_en in those cycles and req_ready[1] stays 0; the burst resumes when req_valid returns.
- Assert rst for one cycle mid-burst with a read pending -> on the next cycle all outputs are 0, no rsp_valid appears, and state is IDLE with rr_ptr=0.

Source files
------------

// File: rtl/iface_arbiter.sv
// Round-robin arbiter sharing one memory interface port between N_REQ masters, with burst locking and read-response routing.
// Latency: 1 cycle arbitration from IDLE, 0-bubble handoff on release; read data returns 1 cycle after the accepted read beat.
// Backpressure: a requester's beat is accepted only while it owns the grant (req_ready); non-owners wait with no timeout.
//
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   req_valid/ready/last     per-requester beat handshake and end-of-burst marker
//   req_rdwr/addr/wr_data/control  per-requester packed beat payloads (slice i belongs to requester i)
//   rsp_valid, rsp_rd_data   read return, rsp_valid one-hot on the issuing requester, data shared
//   interface_*              memory interface port (en/rdwr/addr/wr_data/control out, rd_data in)
module iface_arbiter #(
    parameter int N_REQ     = 2,
    parameter int A_WID     = 32,
    parameter int D_WID     = 128,
    parameter int C_WID     = 5,
    parameter int MAX_BURST = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [N_REQ-1:0]         req_valid,
    output logic [N_REQ-1:0]         req_ready,
    input  logic [N_REQ-1:0]         req_last,
    input  logic [N_REQ-1:0]         req_rdwr,
    input  logic [N_REQ*A_WID-1:0]   req_addr,
    input  logic [N_REQ*D_WID-1:0]   req_wr_data,
    input  logic [N_REQ*C_WID-1:0]   req_control,
    output logic [N_REQ-1:0]         rsp_valid,
    output logic [D_WID-1:0]         rsp_rd_data,
    output logic                     interface_en,
    output logic                     interface_rdwr,
    output logic [A_WID-1:0]         interface_addr,
    output logic [D_WID-1:0]         interface_wr_data,
    output logic [C_WID-1:0]         interface_control,
    input  logic [D_WID-1:0]         interface_rd_data
);

    localparam int OW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int BW = $clog2(MAX_BURST + 1);

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    state_t          state;
    logic [OW-1:0]   owner;
    logic [OW-1:0]   rr_ptr;
    logic [BW-1:0]   beat_cnt;
    logic            rsp_pend;
    logic [OW-1:0]   rsp_id;

    // Circular first-set search starting at 'start'. Returns {found, index}.
    // Walking the offsets backwards lets the closest-to-start hit overwrite the others.
    function automatic logic [OW:0] rr_pick(input logic [N_REQ-1:0] vld, input logic [OW-1:0] start);
        logic [OW:0] res;
        int          idx;
        res = '0;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            idx = (int'(start) + k) % N_REQ;
            if (vld[idx]) begin
                res = {1'b1, OW'(idx)};
            end
        end
        return res;
    endfunction

    function automatic logic [OW-1:0] next_id(input logic [OW-1:0] id);
        logic [OW-1:0] nxt;
        if (int'(id) >= N_REQ - 1) begin
            nxt = '0;
        end else begin
            nxt = id + 1'b1;
        end
        return nxt;
    endfunction

    logic              accept;
    logic              forced;
    logic              release_beat;
    logic [OW-1:0]     owner_next;
    logic [N_REQ-1:0]  owner_mask;
    logic [OW:0]       idle_pick;
    logic [OW:0]       rel_pick;

    // Outputs are held at zero while rst is asserted, not only after the reset edge.
    assign accept       = !rst && (state == GRANT) && req_valid[owner];
    assign forced       = (beat_cnt == BW'(MAX_BURST - 1));
    assign release_beat = accept && (req_last[owner] || forced);
    assign owner_next   = next_id(owner);
    assign owner_mask   = N_REQ'(1) << owner;
    assign idle_pick    = rr_pick(req_valid, rr_ptr);
    // The releasing owner's bit is masked out, so it cannot re-win in its own release cycle;
    // if nobody else is waiting the arbiter drops to IDLE and it may win again from there.
    assign rel_pick     = rr_pick(req_valid & ~owner_mask, owner_next);

    always_comb begin
        req_ready         = '0;
        interface_en      = 1'b0;
        interface_rdwr    = 1'b0;
        interface_addr    = '0;
        interface_wr_data = '0;
        interface_control = '0;
        if (accept) begin
            req_ready[owner]  = 1'b1;
            interface_en      = 1'b1;
            interface_rdwr    = req_rdwr[owner];
            interface_addr    = req_addr[int'(owner)*A_WID +: A_WID];
            interface_wr_data = req_wr_data[int'(owner)*D_WID +: D_WID];
            interface_control = req_control[int'(owner)*C_WID +: C_WID];
        end
    end

    // Read return is steered by the tag captured with the beat, so it lands on the
    // issuer even when the grant has already moved to another requester.
    always_comb begin
        rsp_valid   = '0;
        rsp_rd_data = '0;
        if (rsp_pend && !rst) begin
            rsp_valid[rsp_id] = 1'b1;
            rsp_rd_data       = interface_rd_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            owner    <= '0;
            rr_ptr   <= '0;
            beat_cnt <= '0;
            rsp_pend <= 1'b0;
            rsp_id   <= '0;
        end else begin
            rsp_pend <= accept && !req_rdwr[owner];
            if (accept && !req_rdwr[owner]) begin
                rsp_id <= owner;
            end

            case (state)
                IDLE: begin
                    if (idle_pick[OW]) begin
                        owner <= idle_pick[OW-1:0];
                        state <= GRANT;
                    end
                end
                GRANT: begin
                    if (release_beat) begin
                        beat_cnt <= '0;
                        rr_ptr   <= owner_next;
                        if (rel_pick[OW]) begin
                            owner <= rel_pick[OW-1:0];
                        end else begin
                            state <= IDLE;
                        end
                    end else if (accept) begin
                        beat_cnt <= beat_cnt + 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_iface_arbiter.sv
module tb_iface_arbiter;

    localparam int N  = 2;
    localparam int AW = 32;
    localparam int DW = 128;
    localparam int CW = 5;
    localparam int MB = 16;

    logic              clk = 1'b0;
    logic              rst;
    logic [N-1:0]      req_valid;
    logic [N-1:0]      req_ready;
    logic [N-1:0]      req_last;
    logic [N-1:0]      req_rdwr;
    logic [N*AW-1:0]   req_addr;
    logic [N*DW-1:0]   req_wr_data;
    logic [N*CW-1:0]   req_control;
    logic [N-1:0]      rsp_valid;
    logic [DW-1:0]     rsp_rd_data;
    logic              interface_en;
    logic              interface_rdwr;
    logic [AW-1:0]     interface_addr;
    logic [DW-1:0]     interface_wr_data;
    logic [CW-1:0]     interface_control;
    logic [DW-1:0]     interface_rd_data;

    always #5 clk = ~clk;

    iface_arbiter #(
        .N_REQ(N), .A_WID(AW), .D_WID(DW), .C_WID(CW), .MAX_BURST(MB)
    ) dut (
        .clk(clk),
        .rst(rst),
        .req_valid(req_valid),
        .req_ready(req_ready),
        .req_last(req_last),
        .req_rdwr(req_rdwr),
        .req_addr(req_addr),
        .req_wr_data(req_wr_data),
        .req_control(req_control),
        .rsp_valid(rsp_valid),
        .rsp_rd_data(rsp_rd_data),
        .interface_en(interface_en),
        .interface_rdwr(interface_rdwr),
        .interface_addr(interface_addr),
        .interface_wr_data(interface_wr_data),
        .interface_control(interface_control),
        .interface_rd_data(interface_rd_data)
    );

    // One row = one clock cycle: inputs driven, then expected ready / owner address / response.
    typedef struct {
        logic        rst;
        logic [1:0]  vld;
        logic [1:0]  last;
        logic [1:0]  rdwr;
        logic [31:0] a0;
        logic [31:0] a1;
        logic [1:0]  erdy;
        logic [31:0] eaddr;
        logic [1:0]  ersp;
    } vec_t;

    vec_t tbl[$];
    int   n_chk  = 0;
    int   n_pass = 0;

    function automatic logic [127:0] wd(input int i, input logic [31:0] a);
        return {a, ~a, a ^ 32'h5A5A_5A5A, 32'(i + 1)};
    endfunction

    function automatic logic [4:0] ctl(input int i);
        return (i == 0) ? 5'h03 : 5'h1C;
    endfunction

    function automatic vec_t mk(input logic r, input logic [1:0] vld, last, rdwr,
                                input logic [31:0] a0, a1, input logic [1:0] erdy,
                                input logic [31:0] eaddr, input logic [1:0] ersp);
        vec_t v;
        v.rst = r; v.vld = vld; v.last = last; v.rdwr = rdwr; v.a0 = a0; v.a1 = a1;
        v.erdy = erdy; v.eaddr = eaddr; v.ersp = ersp;
        return v;
    endfunction

    function automatic void add(input logic r, input logic [1:0] vld, last, rdwr,
                                input logic [31:0] a0, a1, input logic [1:0] erdy,
                                input logic [31:0] eaddr, input logic [1:0] ersp);
        tbl.push_back(mk(r, vld, last, rdwr, a0, a1, erdy, eaddr, ersp));
    endfunction

    task automatic check(input string name, input int row, input logic [199:0] act, input logic [199:0] exp);
        n_chk++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s row %0d: got %h expected %h", name, row, act, exp);
        end
    endtask

    task automatic step(input vec_t v, input int row);
        logic [127:0] rd;
        logic [166:0] exp_bus;
        logic [129:0] exp_rsp;
        int           own;
        @(negedge clk);
        rd = {32'hFEED_0000 | 32'(row), 64'h0123_4567_89AB_CDEF, 32'(row * 7 + 1)};
        rst               = v.rst;
        req_valid         = v.vld;
        req_last          = v.last;
        req_rdwr          = v.rdwr;
        req_addr          = {v.a1, v.a0};
        req_wr_data       = {wd(1, v.a1), wd(0, v.a0)};
        req_control       = {ctl(1), ctl(0)};
        interface_rd_data = rd;
        #2;
        own     = v.erdy[1] ? 1 : 0;
        exp_bus = '0;
        if (|v.erdy) begin
            exp_bus = {1'b1, v.rdwr[own], v.eaddr, wd(own, v.eaddr), ctl(own)};
        end
        exp_rsp = '0;
        if (|v.ersp) begin
            exp_rsp = {v.ersp, rd};
        end
        check("ready", row, 200'(req_ready), 200'(v.erdy));
        check("bus", row,
              200'({interface_en, interface_rdwr, interface_addr, interface_wr_data, interface_control}),
              200'(exp_bus));
        check("rsp", row, 200'({rsp_valid, rsp_rd_data}), 200'(exp_rsp));
    endtask

    initial begin
        rst = 1'b1; req_valid = '0; req_last = '0; req_rdwr = '0;
        req_addr = '0; req_wr_data = '0; req_control = '0; interface_rd_data = '0;

        // reset: everything quiet, even with a request pending
        add(1, 2'b00, 2'b00, 2'b00, 0, 0, 2'b00, 0, 2'b00);
        add(1, 2'b00, 2'b00, 2'b00, 0, 0, 2'b00, 0, 2'b00);
        add(1, 2'b01, 2'b00, 2'b00, 'h100, 0, 2'b00, 0, 2'b00);
        // req0 3-beat read burst, responses one cycle behind each beat
        add(0, 2'b01, 2'b00, 2'b00, 'h100, 0, 2'b00, 0, 2'b00);
        add(0, 2'b01, 2'b00, 2'b00, 'h100, 0, 2'b01, 'h100, 2'b00);
        add(0, 2'b01, 2'b00, 2'b00, 'h110, 0, 2'b01, 'h110, 2'b01);
        add(0, 2'b01, 2'b01, 2'b00, 'h120, 0, 2'b01, 'h120, 2'b01);
        add(0, 2'b00, 2'b00, 2'b00, 0, 0, 2'b00, 0, 2'b01);
        add(0, 2'b01, 2'b00, 2'b00, 'h200, 0, 2'b00, 0, 2'b00);   // back in IDLE: arbitration cycle
        add(1, 2'b00, 2'b00, 2'b00, 0, 0, 2'b00, 0, 2'b00);
        // both requesters, 2-beat writes each; handoff without bubble; rr_ptr back at 0
        add(0, 2'b11, 2'b00, 2'b11, 'h300, 'h400, 2'b00, 0, 2'b00);
        add(0, 2'b11, 2'b00, 2'b11, 'h300, 'h400, 2'b01, 'h300, 2'b00);
        add(0, 2'b11, 2'b01, 2'b11, 'h310, 'h400, 2'b01, 'h310, 2'b00);
        add(0, 2'b10, 2'b00, 2'b11, 0, 'h400, 2'b10, 'h400, 2'b00);
        add(0, 2'b10, 2'b10, 2'b11, 0, 'h410, 2'b10, 'h410, 2'b00);
        add(0, 2'b11, 2'b00, 2'b11, 'h320, 'h420, 2'b00, 0, 2'b00);
        add(0, 2'b11, 2'b01, 2'b11, 'h320, 'h420, 2'b01, 'h320, 2'b00);
        add(0, 2'b10, 2'b10, 2'b11, 0, 'h420, 2'b10, 'h420, 2'b00);
        // req1 20 beats without last: forced release after 16, req0 served, req1 resumes
        add(0, 2'b10, 2'b00, 2'b11, 0, 'h500, 2'b00, 0, 2'b00);
        for (int k = 0; k < 16; k++)
            add(0, 2'b11, 2'b00, 2'b11, 'h600, 32'h500 + 32'(16 * k), 2'b10, 32'h500 + 32'(16 * k), 2'b00);
        for (int j = 0; j < 2; j++)
            add(0, 2'b11, (j == 1) ? 2'b01 : 2'b00, 2'b11, 32'h600 + 32'(16 * j), 'h600, 2'b01,
                32'h600 + 32'(16 * j), 2'b00);
        for (int k = 16; k < 20; k++)
            add(0, 2'b10, (k == 19) ? 2'b10 : 2'b00, 2'b11, 0, 32'h500 + 32'(16 * k), 2'b10,
                32'h500 + 32'(16 * k), 2'b00);
        // req0 final read then req1 write: response routed to req0 during req1's beat
        add(0, 2'b01, 2'b00, 2'b10, 'h700, 0, 2'b00, 0, 2'b00);
        add(0, 2'b11, 2'b01, 2'b10, 'h700, 'h800, 2'b01, 'h700, 2'b00);
        add(0, 2'b10, 2'b10, 2'b10, 0, 'h800, 2'b10, 'h800, 2'b01);
        add(0, 2'b00, 2'b00, 2'b10, 0, 0, 2'b00, 0, 2'b00);
        // owner stalls 3 cycles mid-burst; req1 keeps waiting
        add(0, 2'b01, 2'b00, 2'b11, 'h900, 0, 2'b00, 0, 2'b00);
        add(0, 2'b11, 2'b00, 2'b11, 'h900, 'hA00, 2'b01, 'h900, 2'b00);
        for (int k = 0; k < 3; k++)
            add(0, 2'b10, 2'b00, 2'b11, 0, 'hA00, 2'b00, 0, 2'b00);
        add(0, 2'b11, 2'b01, 2'b11, 'h910, 'hA00, 2'b01, 'h910, 2'b00);
        add(0, 2'b10, 2'b10, 2'b11, 0, 'hA00, 2'b10, 'hA00, 2'b00);
        // reset mid-burst with a read pending; afterwards rr_ptr=0 picks req0 first
        add(0, 2'b01, 2'b00, 2'b00, 'hB00, 0, 2'b00, 0, 2'b00);
        add(0, 2'b01, 2'b00, 2'b00, 'hB00, 0, 2'b01, 'hB00, 2'b00);
        add(1, 2'b01, 2'b00, 2'b00, 'hB10, 0, 2'b00, 0, 2'b00);
        add(0, 2'b11, 2'b00, 2'b00, 'hB10, 'hC00, 2'b00, 0, 2'b00);
        add(0, 2'b11, 2'b01, 2'b00, 'hB10, 'hC00, 2'b01, 'hB10, 2'b00);
        add(0, 2'b10, 2'b10, 2'b00, 0, 'hC00, 2'b10, 'hC00, 2'b01);
        add(0, 2'b00, 2'b00, 2'b00, 0, 0, 2'b00, 0, 2'b10);
        add(0, 2'b00, 2'b00, 2'b00, 0, 0, 2'b00, 0, 2'b00);

        for (int i = 0; i < tbl.size(); i++) begin
            step(tbl[i], i);
        end

        // Lone requester hitting the burst cap: forced release goes through IDLE
        // (one arbitration cycle) before the same requester continues.
        step(mk(0, 2'b01, 2'b00, 2'b11, 'hD00, 0, 2'b00, 0, 2'b00), 1000);
        for (int k = 0; k < MB; k++) begin
            step(mk(0, 2'b01, 2'b00, 2'b11, 32'hD00 + 32'(16 * k), 0, 2'b01,
                    32'hD00 + 32'(16 * k), 2'b00), 1001 + k);
        end
        step(mk(0, 2'b01, 2'b00, 2'b11, 'hE00, 0, 2'b00, 0, 2'b00), 1100);
        step(mk(0, 2'b01, 2'b01, 2'b11, 'hE00, 0, 2'b01, 'hE00, 2'b00), 1101);
        step(mk(0, 2'b00, 2'b00, 2'b11, 0, 0, 2'b00, 0, 2'b00), 1102);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
